disp_arb: RTL

- Display-source arbiter and scan scheduler for the 4-digit 7-segment display driver.
- Up to four CPU-side requesters compete for the display. Example requesters: PC, instruction word, register-file probe, ALU result.
- Round-robin grant with a guaranteed minimum visible time per winner.
- The granted 32-bit value is latched, and one half of it is time-multiplexed as hex nibbles with digit-select strobes for the segment encoder.

---
 rtl/disp_arb_if.sv | 24 ++
 rtl/disp_arb.sv | 127 ++++++++++++
 2 files changed

// File: rtl/disp_arb_if.sv
// Display arbiter bus: requester side inputs plus grant status and digit scan outputs.
// The master modport belongs to the CPU/requester side, the slave modport to the arbiter.
interface disp_arb_if;
   logic [3:0]   req;
   logic [127:0] reqData;
   logic         hiHalf;
   logic [3:0]   gnt;
   logic         busy;
   logic [1:0]   dispSrc;
   logic [31:0]  dispVal;
   logic [3:0]   sele;
   logic [3:0]   nib;
   logic         scanTick;

   modport master (
      output req, reqData, hiHalf,
      input  gnt, busy, dispSrc, dispVal, sele, nib, scanTick
   );

   modport slave (
      input  req, reqData, hiHalf,
      output gnt, busy, dispSrc, dispVal, sele, nib, scanTick
   );
endinterface

// File: rtl/disp_arb.sv
// Round-robin display-source arbiter with a minimum hold time per grant, plus a
// free-running digit scanner that serves one 16-bit half of the latched value as hex nibbles.
module disp_arb #(
   parameter int unsigned HOLD_CYC = 32'h003f_0000,
   parameter int unsigned SCAN_DIV = 32'h0000_8000
) (
   input logic     clkIn,
   input logic     rst,
   disp_arb_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   state_e      state_q;
   logic [1:0]  ptr_q;
   logic [31:0] hold_cnt_q;
   logic [3:0]  gnt_q;
   logic        busy_q;
   logic [1:0]  src_q;
   logic [31:0] val_q;

   logic [31:0] scan_cnt_q;
   logic [1:0]  digit_q;
   logic [1:0]  digit_nxt;
   logic [3:0]  sele_q;
   logic [3:0]  nib_q;
   logic        tick_q;

   logic        found;
   logic [1:0]  win;
   logic [1:0]  idx;
   logic        hold_done;

   // Search starts at the pointer and wraps, so the first set bit at or after ptr wins.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      idx   = ptr_q;
      for (int i = 0; i < 4; i++) begin
         idx = ptr_q + i[1:0];
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign hold_done = (hold_cnt_q == HOLD_CYC - 32'd1);
   assign digit_nxt = digit_q + 2'd1;

   always_ff @(posedge clkIn or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         ptr_q      <= 2'd0;
         hold_cnt_q <= 32'd0;
         gnt_q      <= 4'b0000;
         busy_q     <= 1'b0;
         src_q      <= 2'd0;
         val_q      <= 32'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (found) begin
                  state_q    <= StHold;
                  gnt_q      <= 4'b0001 << win;
                  busy_q     <= 1'b1;
                  src_q      <= win;
                  val_q      <= bus.reqData[{win, 5'b00000} +: 32];
                  hold_cnt_q <= 32'd0;
                  ptr_q      <= win + 2'd1;
               end
            end
            StHold: begin
               if (hold_done) begin
                  if (found) begin
                     // Back-to-back regrant: no idle cycle between winners.
                     gnt_q      <= 4'b0001 << win;
                     src_q      <= win;
                     val_q      <= bus.reqData[{win, 5'b00000} +: 32];
                     hold_cnt_q <= 32'd0;
                     ptr_q      <= win + 2'd1;
                  end else begin
                     state_q <= StIdle;
                     gnt_q   <= 4'b0000;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  hold_cnt_q <= hold_cnt_q + 32'd1;
                  // Value freezes once the owner drops its request.
                  if (bus.req[src_q]) begin
                     val_q <= bus.reqData[{src_q, 5'b00000} +: 32];
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clkIn or negedge rst) begin
      if (!rst) begin
         scan_cnt_q <= 32'd0;
         digit_q    <= 2'd0;
         sele_q     <= 4'b1110;
         nib_q      <= 4'h0;
         tick_q     <= 1'b0;
      end else if (scan_cnt_q == SCAN_DIV - 32'd1) begin
         scan_cnt_q <= 32'd0;
         digit_q    <= digit_nxt;
         tick_q     <= 1'b1;
         sele_q     <= ~(4'b0001 << digit_nxt);
         nib_q      <= val_q[{bus.hiHalf, digit_nxt, 2'b00} +: 4];
      end else begin
         scan_cnt_q <= scan_cnt_q + 32'd1;
         tick_q     <= 1'b0;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.busy     = busy_q;
   assign bus.dispSrc  = src_q;
   assign bus.dispVal  = val_q;
   assign bus.sele     = sele_q;
   assign bus.nib      = nib_q;
   assign bus.scanTick = tick_q;

endmodule
